// File: rtl/immediate_interpreter_pkg.sv
// Shared constants for the immediate-operand parser: delimiter/sign ASCII codes
// and the default accumulator width.
package immediate_interpreter_pkg;

  localparam int IMM_WIDTH_DEFAULT = 32;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_COMMA   = 8'h2C;
  localparam logic [7:0] ASCII_LPAREN  = 8'h28;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;
  localparam logic [7:0] ASCII_MINUS   = 8'h2D;
  localparam logic [7:0] ASCII_PLUS    = 8'h2B;
  localparam logic [7:0] ASCII_X_LOWER = 8'h78;
  localparam logic [7:0] ASCII_X_UPPER = 8'h58;

  function automatic logic is_delimiter(input logic [7:0] c);
    return (c == ASCII_SPACE) || (c == ASCII_COMMA) ||
           (c == ASCII_LPAREN) || (c == ASCII_NEWLINE);
  endfunction

endpackage

// File: rtl/immediate_interpreter_ascii_digit_decode.sv
// Combinational ASCII digit classifier. Hex letters (a-f, A-F) are recognised
// only when IMMEDIATE_HEX_EN is defined; otherwise is_hex is tied low.
module ascii_digit_decode (
  input  logic [7:0] ascii,
  output logic [3:0] digit,
  output logic       is_dec,
  output logic       is_hex
);

  logic [7:0] offset;

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    digit  = 4'd0;
    is_dec = 1'b0;
    is_hex = 1'b0;
    offset = 8'd0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      is_dec = 1'b1;
      offset = ascii - 8'h30;
`ifdef IMMEDIATE_HEX_EN
      is_hex = 1'b1;
    end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
      is_hex = 1'b1;
      offset = ascii - 8'h57;
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      is_hex = 1'b1;
      offset = ascii - 8'h37;
`endif
    end
    digit = offset[3:0];
  end

endmodule

// File: rtl/immediate_interpreter.sv
// Parses one immediate operand token ("-42", "0x7ff", "+3") from the character
// stream into a two's-complement value. Hex prefix support: IMMEDIATE_HEX_EN.
module immediate_interpreter
  import immediate_interpreter_pkg::*;
#(
  parameter int IMM_WIDTH = IMM_WIDTH_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_data,
  input  logic                 new_character,
  input  logic [7:0]           incoming_ascii,
  output logic                 error_flag,
  output logic                 done_flag,
  output logic [IMM_WIDTH-1:0] immediate,
  output logic [7:0]           delimiter
);

  typedef enum logic [2:0] {
    IDLE, SIGN, ZERO, DEC, HEX_PRE, HEX, RETURN, ERROR
  } state_t;

  localparam logic [IMM_WIDTH+3:0] NEG_LIMIT = (IMM_WIDTH+4)'(1) << (IMM_WIDTH-1);

  state_t               state;
  logic [IMM_WIDTH-1:0] acc;
  logic                 neg;

  logic [3:0]           digit;
  logic                 is_dec;
  logic                 is_hex;
  logic                 is_delim;
  logic [IMM_WIDTH+3:0] dec_sum;
  logic                 dec_ovf;

  ascii_digit_decode u_decode (
    .ascii  (incoming_ascii),
    .digit  (digit),
    .is_dec (is_dec),
    .is_hex (is_hex)
  );

  assign is_delim = is_delimiter(incoming_ascii);

  // acc*10 + d without a multiplier; the extra 4 bits expose any carry-out.
  assign dec_sum = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (IMM_WIDTH+4)'(digit);
  assign dec_ovf = neg ? (dec_sum > NEG_LIMIT) : (dec_sum[IMM_WIDTH+3:IMM_WIDTH] != 4'b0);

`ifdef IMMEDIATE_HEX_EN
  logic hex_ovf;
  assign hex_ovf = (acc[IMM_WIDTH-1:IMM_WIDTH-4] != 4'b0);
`else
  logic unused_hex;
  assign unused_hex = is_hex;
`endif

  // NOTE: asynchronous active-low reset sits in the sensitivity list; all state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      acc        <= '0;
      neg        <= 1'b0;
      immediate  <= '0;
      delimiter  <= 8'd0;
      error_flag <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      if (!valid_data) begin
        state      <= IDLE;
        error_flag <= 1'b0;
      end else if (state == RETURN) begin
        state <= IDLE;
      end else if (new_character) begin
        case (state)
          IDLE: begin
            acc <= '0;
            neg <= 1'b0;
            if (incoming_ascii == ASCII_SPACE) begin
              state <= IDLE;
            end else if (incoming_ascii == ASCII_MINUS || incoming_ascii == ASCII_PLUS) begin
              state <= SIGN;
              neg   <= (incoming_ascii == ASCII_MINUS);
            end else if (is_dec) begin
              state <= (digit == 4'd0) ? ZERO : DEC;
              acc   <= IMM_WIDTH'(digit);
            end else begin
              state      <= ERROR;
              error_flag <= 1'b1;
            end
          end
          SIGN: begin
            if (is_dec) begin
              state <= (digit == 4'd0) ? ZERO : DEC;
              acc   <= IMM_WIDTH'(digit);
            end else begin
              state      <= ERROR;
              error_flag <= 1'b1;
            end
          end
          ZERO: begin
            if (is_dec) begin
              state <= DEC;
              acc   <= IMM_WIDTH'(digit);
`ifdef IMMEDIATE_HEX_EN
            end else if (incoming_ascii == ASCII_X_LOWER || incoming_ascii == ASCII_X_UPPER) begin
              state <= HEX_PRE;
`endif
            end else if (is_delim) begin
              state     <= RETURN;
              done_flag <= 1'b1;
              immediate <= '0;
              delimiter <= incoming_ascii;
            end else begin
              state      <= ERROR;
              error_flag <= 1'b1;
            end
          end
          DEC: begin
            if (is_dec && !dec_ovf) begin
              acc <= dec_sum[IMM_WIDTH-1:0];
            end else if (is_delim) begin
              state     <= RETURN;
              done_flag <= 1'b1;
              immediate <= neg ? -acc : acc;
              delimiter <= incoming_ascii;
            end else begin
              state      <= ERROR;
              error_flag <= 1'b1;
            end
          end
`ifdef IMMEDIATE_HEX_EN
          HEX_PRE: begin
            if (is_hex) begin
              state <= HEX;
              acc   <= IMM_WIDTH'(digit);
            end else begin
              state      <= ERROR;
              error_flag <= 1'b1;
            end
          end
          HEX: begin
            if (is_hex && !hex_ovf) begin
              acc <= {acc[IMM_WIDTH-5:0], digit};
            end else if (is_delim) begin
              state     <= RETURN;
              done_flag <= 1'b1;
              immediate <= neg ? -acc : acc;
              delimiter <= incoming_ascii;
            end else begin
              state      <= ERROR;
              error_flag <= 1'b1;
            end
          end
`endif
          ERROR:   state <= ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_immediate_interpreter.sv
// Scoreboard bench for immediate_interpreter: expected {immediate, delimiter}
// pairs are queued when a token is driven and popped whenever done_flag fires.
module tb_immediate_interpreter;

  localparam int W = 32;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         valid_data;
  logic         new_character;
  logic [7:0]   incoming_ascii;
  logic         error_flag;
  logic         done_flag;
  logic [W-1:0] immediate;
  logic [7:0]   delimiter;

  typedef struct {
    logic [W-1:0] imm;
    logic [7:0]   delim;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  immediate_interpreter #(.IMM_WIDTH(W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_data     (valid_data),
    .new_character  (new_character),
    .incoming_ascii (incoming_ascii),
    .error_flag     (error_flag),
    .done_flag      (done_flag),
    .immediate      (immediate),
    .delimiter      (delimiter)
  );

  always #5 clk_in = ~clk_in;

  // Every done pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (rst_in && done_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done imm=%h delim=%h required=no done", immediate, delimiter);
      end else begin
        mon_e = exp_q.pop_front();
        if (immediate !== mon_e.imm || delimiter !== mon_e.delim) begin
          failures++;
          $display("FAIL token_result imm=%h delim=%h required imm=%h delim=%h",
                   immediate, delimiter, mon_e.imm, mon_e.delim);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      incoming_ascii = s[i];
      new_character  = 1'b1;
      @(posedge clk_in); #1;
    end
    new_character = 1'b0;
  endtask

  // Queue the expected result, drive the token, then idle through RETURN.
  task automatic token(input string s, input logic [W-1:0] imm, input logic [7:0] delim);
    exp_t e;
    e.imm   = imm;
    e.delim = delim;
    exp_q.push_back(e);
    send(s);
    @(posedge clk_in); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic expect_err(input string name, input logic req);
    checks++;
    if (error_flag !== req) begin
      failures++;
      $display("FAIL %s error_flag=%b required=%b", name, error_flag, req);
    end
  endtask

  task automatic abort_and_check(input string name);
    valid_data = 1'b0;
    @(posedge clk_in); #1;
    valid_data = 1'b1;
    expect_err({name, "_cleared"}, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if ({error_flag, done_flag, immediate, delimiter} !== '0) begin
      failures++;
      $display("FAIL reset_state err=%b done=%b imm=%h delim=%h required all zero",
               error_flag, done_flag, immediate, delimiter);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    e.imm   = 32'hFFFF_FFD6;
    e.delim = ",";
    exp_q.push_back(e);
    send("-42");
    checks++;
    if (done_flag !== 1'b0) begin
      failures++;
      $display("FAIL done_early done=%b required=0", done_flag);
    end
    send(",");
    checks++;
    if (done_flag !== 1'b1) begin
      failures++;
      $display("FAIL done_after_delim done=%b required=1", done_flag);
    end
    @(posedge clk_in); #1;
    checks++;
    if (done_flag !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle done=%b required=0", done_flag);
    end
    token("+3 ", 32'd3, " ");
    drain("basic");
  endtask

  task automatic test_hex();
`ifdef IMMEDIATE_HEX_EN
    token("0x7FF ", 32'h0000_07FF, " ");
    token("0Xffffffff,", 32'hFFFF_FFFF, ",");
    token("-0x10 ", 32'hFFFF_FFF0, " ");
    drain("hex");
    send("0x12345678");
    expect_err("hex_full_ok", 1'b0);
    send("9");
    expect_err("hex_overflow", 1'b1);
    abort_and_check("hex_overflow");
`else
    send("0");
    expect_err("hex_off_zero", 1'b0);
    send("x");
    expect_err("hex_off_x", 1'b1);
    send("7 ");
    abort_and_check("hex_off");
    drain("hex_off");
`endif
  endtask

  task automatic test_bounds();
    token("4294967295 ", 32'hFFFF_FFFF, " ");
    token("-2147483648 ", 32'h8000_0000, " ");
    drain("bounds");
    send("429496729");
    expect_err("pos_max_prefix", 1'b0);
    send("6");
    expect_err("pos_overflow", 1'b1);
    abort_and_check("pos_overflow");
    send("-214748364");
    expect_err("neg_max_prefix", 1'b0);
    send("9");
    expect_err("neg_overflow", 1'b1);
    abort_and_check("neg_overflow");
  endtask

  task automatic test_errors();
    send("-");
    expect_err("sign_only_prefix", 1'b0);
    send(",");
    expect_err("sign_no_digits", 1'b1);
    send("5 ");
    repeat (2) @(posedge clk_in);
    #1;
    expect_err("error_sticky", 1'b1);
    abort_and_check("sign_no_digits");
    token("7,", 32'd7, ",");
    drain("after_error");
`ifdef IMMEDIATE_HEX_EN
    send("0x");
    expect_err("hex_prefix_ok", 1'b0);
    send(" ");
    expect_err("hex_no_digits", 1'b1);
`else
    send("0x");
    expect_err("hex_prefix_rejected", 1'b1);
`endif
    abort_and_check("hex_no_digits");
    send("12");
    expect_err("dec_prefix_ok", 1'b0);
    send("a");
    expect_err("dec_bad_char", 1'b1);
    abort_and_check("dec_bad_char");
  endtask

  task automatic test_delims();
    token("8(", 32'd8, "(");
    token("  5,", 32'd5, ",");
    token("0\n", 32'd0, 8'h0A);
    token("10 ", 32'd10, " ");
    drain("delims");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // '9' lands in RETURN and is dropped, so the trailing ',' hits IDLE.
    e.imm   = 32'd7;
    e.delim = ",";
    exp_q.push_back(e);
    send("7,9,");
    expect_err("return_drops_char", 1'b1);
    drain("return_drop");
    abort_and_check("return_drop");
    token("1 ", 32'd1, " ");
    token("23,", 32'd23, ",");
    token("-0(", 32'd0, "(");
    drain("back_to_back");
  endtask

  task automatic test_abort();
    token("8(", 32'd8, "(");
    drain("pre_reset");
    send("12");
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if ({error_flag, done_flag, immediate, delimiter} !== '0) begin
      failures++;
      $display("FAIL async_reset err=%b done=%b imm=%h delim=%h required all zero",
               error_flag, done_flag, immediate, delimiter);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    token("5,", 32'd5, ",");
    drain("pre_abort");
    send("99");
    valid_data = 1'b0;
    @(posedge clk_in); #1;
    checks++;
    if (immediate !== 32'd5 || delimiter !== ",") begin
      failures++;
      $display("FAIL abort_hold imm=%h delim=%h required imm=%h delim=%h",
               immediate, delimiter, 32'd5, 8'h2C);
    end
    valid_data = 1'b1;
    token("3 ", 32'd3, " ");
    repeat (3) @(posedge clk_in);
    #1;
    drain("after_abort");
  endtask

  initial begin
    rst_in         = 1'b0;
    valid_data     = 1'b0;
    new_character  = 1'b0;
    incoming_ascii = 8'd0;
    repeat (2) @(posedge clk_in);
    #1;
    test_reset();
    rst_in     = 1'b1;
    valid_data = 1'b1;
    @(posedge clk_in); #1;
    test_basic();
    test_hex();
    test_bounds();
    test_errors();
    test_delims();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
